// File: rtl/mem_dump_unit.sv
// Memory dump engine: streams an inclusive SRAM address range out over a
// valid/ready port while holding the CPU, and accumulates a running checksum.
module mem_dump_unit #(
    parameter int word_size = 8,
    parameter int addr_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [addr_size-1:0] first_addr,
    input  logic [addr_size-1:0] last_addr,
    output logic [addr_size-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [word_size-1:0] mem_data,
    output logic                 cpu_hold,
    output logic [word_size-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 busy,
    output logic                 done,
    output logic [word_size-1:0] checksum
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [addr_size-1:0] cur;
    logic [addr_size-1:0] last;
    logic [word_size-1:0] dout_q;
    logic [word_size-1:0] sum;
    logic                 hs;

    assign hs = (state == SEND) && dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = READ;
            READ: state_nxt = WAIT;
            WAIT: state_nxt = SEND;
            SEND: if (dout_ready) state_nxt = (cur == last) ? DONE : READ;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // cur stays on the last address after the final word so mem_addr is stable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur    <= '0;
            last   <= '0;
            dout_q <= '0;
            sum    <= '0;
        end else begin
            if (state == IDLE && start) begin
                cur  <= first_addr;
                last <= last_addr;
                sum  <= '0;
            end
            if (state == WAIT) dout_q <= mem_data;
            if (hs) begin
                sum <= sum + dout_q;
                if (cur != last) cur <= cur + addr_size'(1);
            end
        end
    end

    assign mem_addr   = cur;
    assign mem_rd     = (state == READ);
    assign busy       = (state != IDLE);
    assign cpu_hold   = (state != IDLE);
    assign done       = (state == DONE);
    assign dout_valid = (state == SEND);
    assign dout       = dout_q;
    assign checksum   = sum;

endmodule

// File: doc/mem_dump_unit.md
MEM_DUMP_UNIT -- requirements
Module: mem_dump_unit

Interface
REQ-001 SHALL have parameter word_size, default 8, data width in bits.
REQ-002 SHALL have parameter addr_size, default 8, memory address width in bits (256-word space).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have port first_addr  input  addr_size  first address of the range, sampled on accepted start.
REQ-007 SHALL have port last_addr  input  addr_size  last address of the range, inclusive, sampled on accepted start.
REQ-008 SHALL have port mem_addr  output  addr_size  SRAM read address.
REQ-009 SHALL have port mem_rd  output  1  SRAM read strobe; data returns on mem_data one cycle later.
REQ-010 SHALL have port mem_data  input  word_size  SRAM read data.
REQ-011 SHALL have port cpu_hold  output  1  stalls the processor while the dump owns memory.
REQ-012 SHALL have port dout  output  word_size  streamed memory word.
REQ-013 SHALL have port dout_valid  output  1  dout holds a word.
REQ-014 SHALL have port dout_ready  input  1  consumer accepts dout.
REQ-015 SHALL have port busy  output  1  dump in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of dump.
REQ-017 SHALL have port checksum  output  word_size  modulo-2^word_size sum of words transferred.

Function
REQ-018 SHALL implement states IDLE, READ, WAIT, SEND, DONE.
REQ-019 IDLE: start=1 SHALL load cur=first_addr, latch last_addr, clear checksum, go to READ.
REQ-020 READ: mem_rd=1, mem_addr=cur for exactly one cycle, next state WAIT.
REQ-021 WAIT: SHALL register mem_data into dout at the closing edge, next state SEND.
REQ-022 SEND: dout_valid=1 and dout stable until the cycle where dout_ready=1 (handshake).
REQ-023 On handshake: checksum += dout (wrap mod 2^word_size); if cur==last go to DONE, else cur=cur+1 (wrap 255->0) and go to READ.
REQ-024 DONE: done=1 for one cycle, next state IDLE; checksum SHALL hold its value until next accepted start.
REQ-025 Latency: first dout_valid SHALL rise 3 edges after the edge sampling start; each further word 3 cycles after previous handshake with dout_ready held high.
REQ-026 Range: first_addr==last_addr dumps one word; last_addr<first_addr wraps through address 255 to 0; word count = (last-first) mod 256 + 1.
REQ-027 start while busy=1 SHALL be ignored with no effect on cur, last or checksum.
REQ-028 busy and cpu_hold SHALL be 1 in READ, WAIT, SEND, DONE and 0 in IDLE.
REQ-029 mem_rd SHALL be 0 outside READ; mem_addr SHALL equal cur at all times.
REQ-030 dout_ready asserted outside SEND SHALL have no effect.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE and clear cur, last, dout, checksum, mem_addr to 0 and mem_rd, dout_valid, busy, done, cpu_hold to 0.
REQ-032 Reset mid-dump SHALL abandon the transfer with no done pulse; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 Memory 128..131 = 6,1,2,0; start first=128 last=131, dout_ready=1 -> dout 6,1,2,0 in order, done once, checksum 9, busy low after DONE.
REQ-034 Same range, dout_ready low 5 cycles on word 2 -> dout=1 held with dout_valid=1 all 5 cycles, no extra mem_rd, checksum still 9.
REQ-035 Memory 254=0xF0, 255=0x20, 0=0x00, 1=0x50; first=254 last=1 -> 4 words F0,20,00,50 via address wrap, checksum 0x60.
REQ-036 first=last=139 with memory[139]=0xF0 -> exactly one mem_rd, one word 0xF0, checksum 0xF0, done 4 edges after start with ready high.
REQ-037 start pulsed again during SEND of range 128..131 -> ignored, 4 words and checksum 9 unchanged.
REQ-038 rst=0 asynchronously during WAIT of second word -> all outputs 0 immediately, no done; new start 128..128 afterwards -> single word 6, checksum 6.
